// File: rtl/phy_tx_sched.sv
// rtl/phy_tx_sched.sv - round-robin word scheduler in front of phy_tx (option: PHY_TX_SCHED_PRIORITY_EN)
module phy_tx_sched #(
    parameter int          NUM_REQ      = 4,
    parameter int          MAX_BURST    = 4,
    parameter int          SYNC_WORDS   = 8,
    parameter logic [31:0] SYNC_PATTERN = 32'hBCBC_BCBC
) (
    input  logic                    clk_f,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      grant,
    output logic [31:0]             data_out,
    output logic                    valid_out,
    output logic [2:0]              src_id,
    output logic                    sync_done
);

    typedef enum logic [1:0] {SYNC, ARB, BURST} state_t;

    state_t               state_q;
    logic [7:0]           sync_cnt_q;
    logic [3:0]           burst_cnt_q;
    logic [2:0]           rr_q;
    logic [2:0]           k_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [31:0]          data_q;
    logic                 valid_q;
    logic [2:0]           src_q;
    logic                 sync_done_q;

    logic [7:0]           req_pad;
    logic                 win_found;
    logic [2:0]           win_idx;
    logic [3:0]           scan;
    logic [31:0]          word_k;
    logic                 req_k;
    logic                 cap_hit;
    logic [2:0]           rr_next;

    // Winner search: first requester at or after the rr pointer, wrapping.
    always_comb begin
        req_pad   = 8'(req);
        win_found = 1'b0;
        win_idx   = 3'd0;
        scan      = 4'd0;
`ifdef PHY_TX_SCHED_PRIORITY_EN
        // Requester 0 pre-empts the rotation; it is skipped in the scan below.
        if (req_pad[0]) begin
            win_found = 1'b1;
        end
`endif
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rr_q} + 4'(i);
            if (scan >= 4'(NUM_REQ)) begin
                scan = scan - 4'(NUM_REQ);
            end
`ifdef PHY_TX_SCHED_PRIORITY_EN
            if (!win_found && req_pad[scan[2:0]] && (scan != 4'd0)) begin
`else
            if (!win_found && req_pad[scan[2:0]]) begin
`endif
                win_found = 1'b1;
                win_idx   = scan[2:0];
            end
        end
    end

    // Current grant holder's word, request and burst-end conditions.
    always_comb begin
        word_k = 32'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (k_q == 3'(i)) begin
                word_k = req_data[32*i +: 32];
            end
        end
        req_k   = req_pad[k_q];
        rr_next = (k_q == 3'(NUM_REQ - 1)) ? 3'd0 : k_q + 3'd1;
`ifdef PHY_TX_SCHED_PRIORITY_EN
        cap_hit = (burst_cnt_q == 4'(MAX_BURST - 1)) && (k_q != 3'd0);
`else
        cap_hit = (burst_cnt_q == 4'(MAX_BURST - 1));
`endif
    end

    // Scheduler FSM: link training, arbitration and burst transfer with registered outputs.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_q     <= SYNC;
            sync_cnt_q  <= 8'd0;
            burst_cnt_q <= 4'd0;
            rr_q        <= 3'd0;
            k_q         <= 3'd0;
            grant_q     <= '0;
            data_q      <= 32'd0;
            valid_q     <= 1'b0;
            src_q       <= 3'd0;
            sync_done_q <= 1'b0;
        end else begin
            case (state_q)
                SYNC: begin
                    data_q     <= SYNC_PATTERN;
                    valid_q    <= 1'b1;
                    src_q      <= 3'd0;
                    grant_q    <= '0;
                    sync_cnt_q <= sync_cnt_q + 8'd1;
                    if (sync_cnt_q == 8'(SYNC_WORDS - 1)) begin
                        state_q <= ARB;
                    end
                end
                ARB: begin
                    valid_q     <= 1'b0;
                    sync_done_q <= 1'b1;
                    if (win_found) begin
                        grant_q     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
                        k_q         <= win_idx;
                        burst_cnt_q <= 4'd0;
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    if (req_k) begin
                        data_q      <= word_k;
                        valid_q     <= 1'b1;
                        src_q       <= k_q;
                        burst_cnt_q <= burst_cnt_q + 4'd1;
                    end else begin
                        valid_q <= 1'b0;
                    end
                    if (!req_k || cap_hit) begin
                        grant_q <= '0;
                        state_q <= ARB;
`ifdef PHY_TX_SCHED_PRIORITY_EN
                        if (k_q != 3'd0) begin
                            rr_q <= rr_next;
                        end
`else
                        rr_q <= rr_next;
`endif
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    assign grant     = grant_q;
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign src_id    = src_q;
    assign sync_done = sync_done_q;

endmodule

// File: tb/tb_phy_tx_sched.sv
// tb/tb_phy_tx_sched.sv - randomized self-checking bench for phy_tx_sched
module tb_phy_tx_sched;

    localparam int          N   = 4;
    localparam int          MB  = 4;
    localparam int          SW  = 8;
    localparam logic [31:0] PAT = 32'hBCBC_BCBC;

    logic               clk_f = 1'b0;
    logic               reset = 1'b1;
    logic [N-1:0]       req = '0;
    logic [32*N-1:0]    req_data = '0;
    logic [N-1:0]       grant;
    logic [31:0]        data_out;
    logic               valid_out;
    logic [2:0]         src_id;
    logic               sync_done;

    phy_tx_sched #(
        .NUM_REQ      (N),
        .MAX_BURST    (MB),
        .SYNC_WORDS   (SW),
        .SYNC_PATTERN (PAT)
    ) dut (
        .clk_f     (clk_f),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .data_out  (data_out),
        .valid_out (valid_out),
        .src_id    (src_id),
        .sync_done (sync_done)
    );

    always #5 clk_f = ~clk_f;

    int checks = 0;
    int errors = 0;

    // Reference model: phase flags, current owner and per-requester word streams.
    bit           m_insync;
    int           m_sync;
    int           m_owner;
    int           m_words;
    int           m_ptr;
    int           seq [N];
    logic [31:0]  e_data;
    bit           e_valid;
    int           e_src;
    logic [N-1:0] e_grant;
    bit           e_sd;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input int i);
        return {8'(i + 1), 24'(seq[i])};
    endfunction

    task automatic model_reset();
        m_insync = 1;
        m_sync   = 0;
        m_owner  = -1;
        m_words  = 0;
        m_ptr    = 0;
        e_data   = 32'd0;
        e_valid  = 0;
        e_src    = 0;
        e_grant  = '0;
        e_sd     = 0;
    endtask

    function automatic int pick();
`ifdef PHY_TX_SCHED_PRIORITY_EN
        if (req[0]) return 0;
`endif
        for (int i = 0; i < N; i++) begin
            int idx;
            idx = (m_ptr + i) % N;
`ifdef PHY_TX_SCHED_PRIORITY_EN
            if (idx == 0) continue;
`endif
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock edge of the scheduler as seen from outside.
    task automatic model_step();
        if (m_insync) begin
            e_data  = PAT;
            e_valid = 1;
            e_src   = 0;
            e_grant = '0;
            m_sync++;
            if (m_sync == SW) m_insync = 0;
        end else if (m_owner < 0) begin
            int w;
            e_valid = 0;
            e_sd    = 1;
            w = pick();
            if (w >= 0) begin
                m_owner = w;
                m_words = 0;
                e_grant = N'(1) << w;
            end
        end else begin
            bit fin;
            bit capped;
            capped = 1;
`ifdef PHY_TX_SCHED_PRIORITY_EN
            if (m_owner == 0) capped = 0;
`endif
            fin = 0;
            if (req[m_owner]) begin
                e_data  = word_of(m_owner);
                e_valid = 1;
                e_src   = m_owner;
                seq[m_owner]++;
                m_words++;
                if (capped && m_words == MB) fin = 1;
            end else begin
                e_valid = 0;
                fin = 1;
            end
            if (fin) begin
                e_grant = '0;
                if (capped) m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < N; i++) req_data[32*i +: 32] = word_of(i);
    endtask

    task automatic compare_all();
        chk("data_out",  data_out,          e_data);
        chk("valid_out", 32'(valid_out),    32'(e_valid));
        chk("src_id",    32'(src_id),       32'(e_src));
        chk("grant",     32'(grant),        32'(e_grant));
        chk("sync_done", 32'(sync_done),    32'(e_sd));
    endtask

    task automatic cycle();
        @(posedge clk_f);
        if (!reset) model_step();
        @(negedge clk_f);
        compare_all();
    endtask

    task automatic rand_req();
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                req[i] = 1'b1;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 1;
        model_reset();
        drive_data();
        @(negedge clk_f);
        @(negedge clk_f);
        compare_all();
        reset = 1'b0;

        // Training with no requests, then idle arbitration.
        for (int c = 0; c < 12; c++) cycle();

        // Sole requester 1 with back-to-back bursts.
        req = 4'b0010;
        for (int c = 0; c < 14; c++) begin
            cycle();
            drive_data();
        end

        // All requesters held: full rotation.
        req = 4'b1111;
        for (int c = 0; c < 26; c++) begin
            cycle();
            drive_data();
        end

        // Random request patterns.
        for (int c = 0; c < 400; c++) begin
            cycle();
            drive_data();
            rand_req();
        end

        // Reset in the middle of a burst.
        req = 4'b1111;
        for (int c = 0; c < 40 && !(m_owner >= 0 && m_words > 0); c++) begin
            cycle();
            drive_data();
        end
        chk("mid_burst_reached", 32'(m_owner >= 0 && m_words > 0), 32'd1);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(negedge clk_f);
        compare_all();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            drive_data();
        end

        for (int c = 0; c < 300; c++) begin
            cycle();
            drive_data();
            rand_req();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
